path_replayer: RTL and testbench
================================

PATH_REPLAYER -- requirements
Module: path_replayer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: `clk` input 1, the rising-edge clock, and `rst` input 1, the asynchronous active-high reset.
REQ-002 `start` input 1: a one-cycle pulse that begins replay from cell (0,0).
REQ-003 `q_empty` input 1: the move queue holds no entry.
REQ-004 `move` input 2: the head-of-queue move, show-ahead, valid whenever `q_empty`=0.
REQ-005 `q_rd` output 1: pops the queue head at the next rising edge.
REQ-006 `mem_x`, `mem_y` output 4 each: the maze-memory cell query address.
REQ-007 `wall` input 1: combinational maze-memory response for (`mem_x`,`mem_y`); 1 means blocked.
REQ-008 `pos_x`, `pos_y` output 4 each: the current replayed cell.
REQ-009 `step_count` output 8: the number of moves applied.
REQ-010 `busy`, `done`, `error` output 1 each: status flags.

Function
REQ-011 Move encoding SHALL be: 2'b00 means y+1, 2'b01 means x-1, 2'b10 means x+1, 2'b11 means y-1.
REQ-012 The FSM SHALL have states IDLE, FETCH, CHECK, STEP, DONE, ERR.
REQ-013 IDLE, DONE and ERR SHALL behave as follows on `start`=1:
- clear `pos_x`, `pos_y` and `step_count`;
- clear `done` and `error`;
- go to FETCH.
Otherwise these states hold.
REQ-014 FETCH SHALL behave as follows:
- If `q_empty`=0: latch `move` into an internal register, assert `q_rd` for exactly this cycle, and go to CHECK.
- If `q_empty`=1: hold with `q_rd`=0, with no timeout.
REQ-015 `q_rd` SHALL never be asserted while `q_empty`=1 or outside FETCH.
REQ-016 In CHECK, the next cell SHALL be the latched move applied to (`pos_x`,`pos_y`).
- Moves 2'b01 at x=0, 2'b10 at x=15, 2'b11 at y=0 and 2'b00 at y=15 are off-grid.
- An off-grid move goes to ERR, with no wraparound.
REQ-017 In CHECK with an on-grid move, `mem_x`/`mem_y` SHALL equal the next cell, and `wall` SHALL be sampled at the closing edge.
- `wall`=1 goes to ERR.
- `wall`=0 goes to STEP.
REQ-018 STEP SHALL behave as follows:
- update `pos_x`/`pos_y` to the next cell;
- increment `step_count`, saturating at 255;
- if the new cell is (15,15), go to DONE, otherwise go to FETCH.
REQ-019 Per-move latency SHALL be 3 cycles (FETCH, CHECK, STEP) when the queue is non-empty.
REQ-020 `mem_x`/`mem_y` SHALL be 0 outside CHECK.
REQ-021 `busy` SHALL be 1 in FETCH, CHECK and STEP. `done` SHALL be 1 only in DONE. `error` SHALL be 1 only in ERR.
REQ-022 In ERR, `pos_x`, `pos_y` and `step_count` SHALL hold their last valid values.
REQ-023 `start` asserted while `busy`=1 SHALL be ignored.
REQ-024 Moves remaining in the queue after DONE SHALL NOT be popped.

Reset
REQ-025 Asserting `rst` SHALL immediately force the following, regardless of clock:
- state IDLE;
- `pos_x`, `pos_y`, `step_count` and the move register to 0;
- `q_rd`, `busy`, `done` and `error` to 0;
- `mem_x`/`mem_y` to 0.
REQ-026 Reset mid-replay SHALL abandon the replay. No `q_rd` is issued in the cycle in which `rst` is high.

Configuration
REQ-027 With macro `PATH_REPLAYER_WALL_CHECK_EN` defined:
- CHECK queries memory per REQ-017;
- per-move latency is 3 cycles.
REQ-028 Without `PATH_REPLAYER_WALL_CHECK_EN`:
- CHECK still performs the off-grid test of REQ-016, then proceeds directly to STEP;
- `wall` is ignored;
- `mem_x`/`mem_y` are tied to 0;
- latency is unchanged at 3 cycles.

Verification
REQ-029 Scenario: reset then `start`; queue holds 15×2'b10 then 15×2'b00; `wall`=0 everywhere.
- Required: `done`=1 with `pos_x`=15, `pos_y`=15 and `step_count`=30.
- Exactly 30 `q_rd` pulses.
- 90 cycles from FETCH entry to DONE.
REQ-030 Scenario: queue holds 2'b01 at (0,0).
- Required: `error`=1, `pos_x`=0, `pos_y`=0, `step_count`=0.
- One `q_rd` pulse.
REQ-031 Scenario: `wall`=1 at cell (1,0); queue holds 2'b10.
- Required with the macro: CHECK drives `mem_x`=1, `mem_y`=0, then `error`=1 with `step_count`=0.
- Required without the macro: `pos_x`=1, `step_count`=1.
REQ-032 Scenario: queue empty for 20 cycles after `start`, then one 2'b00 arrives.
- Required: `busy`=1 and `q_rd`=0 throughout the wait.
- Then `pos_y`=1 and `step_count`=1.
REQ-033 Scenario: `rst` pulsed during CHECK of the 5th move.
- Required: immediately `pos_x`=0, `pos_y`=0, `step_count`=0, `busy`=0, IDLE.
- A subsequent `start` replays correctly.
REQ-034 Scenario: `start` pulsed while `busy`=1, and a second `start` in DONE.
- Required: the first `start` is ignored.
- The second `start` clears `pos_x`, `pos_y`, `step_count` and `done`, and re-enters FETCH.

Source files
------------

// File: rtl/path_replayer_if.sv
// Handshake bundle between the move queue / maze memory side and the path replayer.
interface path_replayer_if;
  logic       start;
  logic       q_empty;
  logic [1:0] move;
  logic       q_rd;
  logic [3:0] mem_x;
  logic [3:0] mem_y;
  logic       wall;
  logic [3:0] pos_x;
  logic [3:0] pos_y;
  logic [7:0] step_count;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output start, q_empty, move, wall,
    input  q_rd, mem_x, mem_y, pos_x, pos_y, step_count, busy, done, error
  );

  modport slave (
    input  start, q_empty, move, wall,
    output q_rd, mem_x, mem_y, pos_x, pos_y, step_count, busy, done, error
  );
endinterface

// File: rtl/path_replayer.sv
// Replays a queued sequence of moves across a 16x16 maze from (0,0) towards (15,15).
// Build option: define PATH_REPLAYER_WALL_CHECK_EN to query the maze memory for walls in CHECK.
module path_replayer (
  input  logic            clk,
  input  logic            rst,
  path_replayer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t     state_r;
  state_t     state_nx_s;
  logic [1:0] move_r;
  logic [3:0] pos_x_r;
  logic [3:0] pos_y_r;
  logic [7:0] step_r;
  logic       busy_r;
  logic       done_r;
  logic       error_r;
  logic [3:0] nx_x_s;
  logic [3:0] nx_y_s;
  logic       off_grid_s;
  logic       blocked_s;

  // Candidate next cell from the latched move; edges of the grid are fatal, never wrapped.
  always_comb begin
    nx_x_s     = pos_x_r;
    nx_y_s     = pos_y_r;
    off_grid_s = 1'b0;
    case (move_r)
      2'b00: if (pos_y_r == 4'd15) off_grid_s = 1'b1; else nx_y_s = pos_y_r + 4'd1;
      2'b01: if (pos_x_r == 4'd0)  off_grid_s = 1'b1; else nx_x_s = pos_x_r - 4'd1;
      2'b10: if (pos_x_r == 4'd15) off_grid_s = 1'b1; else nx_x_s = pos_x_r + 4'd1;
      2'b11: if (pos_y_r == 4'd0)  off_grid_s = 1'b1; else nx_y_s = pos_y_r - 4'd1;
      default: off_grid_s = 1'b0;
    endcase
  end

`ifdef PATH_REPLAYER_WALL_CHECK_EN
  assign blocked_s = bus.wall;
  assign bus.mem_x = (state_r == CHECK && !off_grid_s) ? nx_x_s : 4'd0;
  assign bus.mem_y = (state_r == CHECK && !off_grid_s) ? nx_y_s : 4'd0;
`else
  logic wall_unused_s;
  assign wall_unused_s = bus.wall;
  assign blocked_s     = 1'b0;
  assign bus.mem_x     = 4'd0;
  assign bus.mem_y     = 4'd0;
`endif

  // Next-state decode; start is only honoured from the resting states.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE, DONE, ERR: if (bus.start) state_nx_s = FETCH; else state_nx_s = state_r;
      FETCH:           if (!bus.q_empty) state_nx_s = CHECK; else state_nx_s = FETCH;
      CHECK:           if (off_grid_s || blocked_s) state_nx_s = ERR; else state_nx_s = STEP;
      STEP:            if (nx_x_s == 4'd15 && nx_y_s == 4'd15) state_nx_s = DONE;
                       else state_nx_s = FETCH;
      default:         state_nx_s = IDLE;
    endcase
  end

  // State, datapath registers and status flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      move_r  <= 2'b00;
      pos_x_r <= 4'd0;
      pos_y_r <= 4'd0;
      step_r  <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == FETCH) || (state_nx_s == CHECK) || (state_nx_s == STEP);
      done_r  <= (state_nx_s == DONE);
      error_r <= (state_nx_s == ERR);
      case (state_r)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            pos_x_r <= 4'd0;
            pos_y_r <= 4'd0;
            step_r  <= 8'd0;
          end
        end
        FETCH: begin
          if (!bus.q_empty) move_r <= bus.move;
        end
        STEP: begin
          pos_x_r <= nx_x_s;
          pos_y_r <= nx_y_s;
          if (step_r != 8'd255) step_r <= step_r + 8'd1;
        end
        default: begin
          move_r <= move_r;
        end
      endcase
    end
  end

  // The pop must land in the FETCH cycle itself, so it is decoded from the state register.
  assign bus.q_rd       = (state_r == FETCH) && !bus.q_empty;
  assign bus.pos_x      = pos_x_r;
  assign bus.pos_y      = pos_y_r;
  assign bus.step_count = step_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.error      = error_r;

endmodule

// File: tb/tb_path_replayer.sv
// Directed, table-driven bench for path_replayer with a behavioural move queue and maze memory.
module tb_path_replayer;

`ifdef PATH_REPLAYER_WALL_CHECK_EN
  localparam bit WC = 1'b1;
`else
  localparam bit WC = 1'b0;
`endif

  typedef struct {
    int          n;
    logic [63:0] mv;
    logic        wall_en;
    logic [3:0]  wx;
    logic [3:0]  wy;
    int          ex;
    int          ey;
    int          esc;
    logic        edone;
    logic        eerr;
    logic        ebusy;
    int          epops;
    int          ecyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  path_replayer_if bus();
  path_replayer dut (.clk(clk), .rst(rst), .bus(bus));

  logic [1:0] qmem [0:511];
  int         qn = 0;
  int         head = 0;
  logic       q_load;
  logic       wall_en;
  logic [3:0] wall_x;
  logic [3:0] wall_y;
  int         nvec = 0;
  int         nfail = 0;
  vec_t       vecs [8];

  always_comb begin
    bus.q_empty = (head >= qn);
    bus.move    = (head < 512) ? qmem[head] : 2'b00;
  end

  always_comb bus.wall = wall_en && (bus.mem_x == wall_x) && (bus.mem_y == wall_y);

  always @(posedge clk) begin
    if (q_load) head <= 0;
    else if (bus.q_rd) head <= head + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] a, input int na, input logic [1:0] b,
                                     input int nb, input logic [1:0] c, input int nc);
    logic [63:0] r;
    int k;
    r = 64'd0;
    k = 0;
    for (int i = 0; i < na; i++) begin r[2*k +: 2] = a; k++; end
    for (int i = 0; i < nb; i++) begin r[2*k +: 2] = b; k++; end
    for (int i = 0; i < nc; i++) begin r[2*k +: 2] = c; k++; end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    q_load = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_load = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Runs until done/error, or until the queue is drained and the DUT sits busy-waiting.
  task automatic run_until(input string name, input int maxc, output int cyc);
    int idle;
    bit fin;
    cyc = 0;
    idle = 0;
    fin = 1'b0;
    for (int i = 0; i < maxc && !fin; i++) begin
      if (bus.done || bus.error) fin = 1'b1;
      else begin
        if (bus.busy) cyc++;
        if (bus.busy && head >= qn) idle++;
        if (idle > 6) fin = 1'b1;
        else @(negedge clk);
      end
    end
    check({name, "_settle"}, {31'd0, fin}, 32'd1);
  endtask

  task automatic load_path(input int base);
    for (int i = 0; i < 15; i++) qmem[base + i] = 2'b10;
    for (int i = 15; i < 30; i++) qmem[base + i] = 2'b00;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    q_load = 1'b1;
    bus.start = 1'b0;
    wall_en = 1'b0;
    wall_x = 4'd0;
    wall_y = 4'd0;

    vecs[0] = '{n:30, mv:mk(2'b10,15,2'b00,15,2'b00,0), wall_en:1'b0, wx:4'd0, wy:4'd0,
                ex:15, ey:15, esc:30, edone:1'b1, eerr:1'b0, ebusy:1'b0, epops:30, ecyc:90};
    vecs[1] = '{n:1, mv:mk(2'b01,1,2'b00,0,2'b00,0), wall_en:1'b0, wx:4'd0, wy:4'd0,
                ex:0, ey:0, esc:0, edone:1'b0, eerr:1'b1, ebusy:1'b0, epops:1, ecyc:-1};
    vecs[2] = '{n:1, mv:mk(2'b10,1,2'b00,0,2'b00,0), wall_en:1'b1, wx:4'd1, wy:4'd0,
                ex:WC ? 0 : 1, ey:0, esc:WC ? 0 : 1, edone:1'b0, eerr:WC, ebusy:!WC,
                epops:1, ecyc:-1};
    vecs[3] = '{n:2, mv:mk(2'b10,1,2'b11,1,2'b00,0), wall_en:1'b0, wx:4'd0, wy:4'd0,
                ex:1, ey:0, esc:1, edone:1'b0, eerr:1'b1, ebusy:1'b0, epops:2, ecyc:-1};
    vecs[4] = '{n:16, mv:mk(2'b00,16,2'b00,0,2'b00,0), wall_en:1'b0, wx:4'd0, wy:4'd0,
                ex:0, ey:15, esc:15, edone:1'b0, eerr:1'b1, ebusy:1'b0, epops:16, ecyc:-1};
    vecs[5] = '{n:32, mv:mk(2'b10,15,2'b00,15,2'b01,2), wall_en:1'b0, wx:4'd0, wy:4'd0,
                ex:15, ey:15, esc:30, edone:1'b1, eerr:1'b0, ebusy:1'b0, epops:30, ecyc:90};
    vecs[6] = '{n:4, mv:mk(2'b10,2,2'b00,1,2'b01,1), wall_en:1'b0, wx:4'd0, wy:4'd0,
                ex:1, ey:1, esc:4, edone:1'b0, eerr:1'b0, ebusy:1'b1, epops:4, ecyc:-1};
    vecs[7] = '{n:30, mv:mk(2'b10,15,2'b00,15,2'b00,0), wall_en:1'b1, wx:4'd3, wy:4'd0,
                ex:WC ? 2 : 15, ey:WC ? 0 : 15, esc:WC ? 2 : 30, edone:!WC, eerr:WC,
                ebusy:1'b0, epops:WC ? 3 : 30, ecyc:WC ? -1 : 90};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    q_load = 1'b0;
    @(negedge clk);
    check("rst_pos", {24'd0, bus.pos_x, bus.pos_y}, 32'd0);
    check("rst_step", {24'd0, bus.step_count}, 32'd0);
    check("rst_flags", {28'd0, bus.busy, bus.done, bus.error, bus.q_rd}, 32'd0);
    check("rst_mem", {24'd0, bus.mem_x, bus.mem_y}, 32'd0);

    // Table-driven replays.
    for (int v = 0; v < 8; v++) begin
      wall_en = vecs[v].wall_en;
      wall_x = vecs[v].wx;
      wall_y = vecs[v].wy;
      qn = vecs[v].n;
      for (int i = 0; i < vecs[v].n; i++) qmem[i] = vecs[v].mv[2*i +: 2];
      do_reset();
      pulse_start();
      run_until($sformatf("v%0d", v), 400, cyc);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_pos_x", v), {28'd0, bus.pos_x}, vecs[v].ex);
      check($sformatf("v%0d_pos_y", v), {28'd0, bus.pos_y}, vecs[v].ey);
      check($sformatf("v%0d_step", v), {24'd0, bus.step_count}, vecs[v].esc);
      check($sformatf("v%0d_done", v), {31'd0, bus.done}, {31'd0, vecs[v].edone});
      check($sformatf("v%0d_error", v), {31'd0, bus.error}, {31'd0, vecs[v].eerr});
      check($sformatf("v%0d_busy", v), {31'd0, bus.busy}, {31'd0, vecs[v].ebusy});
      check($sformatf("v%0d_pops", v), head, vecs[v].epops);
      check($sformatf("v%0d_mem_idle", v), {24'd0, bus.mem_x, bus.mem_y}, 32'd0);
      if (vecs[v].ecyc >= 0) check($sformatf("v%0d_cycles", v), cyc, vecs[v].ecyc);
    end
    wall_en = 1'b0;

    // Wall query address presented during CHECK.
    wall_en = 1'b1; wall_x = 4'd1; wall_y = 4'd0;
    qmem[0] = 2'b10; qn = 1;
    do_reset();
    pulse_start();
    check("wq_fetch_qrd", {31'd0, bus.q_rd}, 32'd1);
    @(negedge clk);
    check("wq_check_qrd", {31'd0, bus.q_rd}, 32'd0);
    check("wq_mem", {24'd0, bus.mem_x, bus.mem_y}, WC ? 32'h10 : 32'h00);
    wall_en = 1'b0;

    // Empty queue wait, then a single late move.
    qn = 0;
    do_reset();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("wait%0d_busy_qrd", i), {30'd0, bus.busy, bus.q_rd}, 32'd2);
      @(negedge clk);
    end
    qmem[0] = 2'b00;
    qn = 1;
    run_until("late", 60, cyc);
    check("late_pos", {24'd0, bus.pos_x, bus.pos_y}, 32'h01);
    check("late_step", {24'd0, bus.step_count}, 32'd1);
    check("late_pops", head, 32'd1);

    // Step counter saturation on a back-and-forth path.
    qn = 260;
    for (int i = 0; i < 260; i++) qmem[i] = (i % 2 == 0) ? 2'b10 : 2'b01;
    do_reset();
    pulse_start();
    run_until("sat", 1000, cyc);
    check("sat_step", {24'd0, bus.step_count}, 32'd255);
    check("sat_pos", {24'd0, bus.pos_x, bus.pos_y}, 32'd0);
    check("sat_pops", head, 32'd260);

    // Reset asserted during CHECK of the 5th move, then a clean replay.
    load_path(0);
    qn = 30;
    do_reset();
    pulse_start();
    repeat (13) @(negedge clk);
    check("m5_pos_x", {28'd0, bus.pos_x}, 32'd4);
    check("m5_mem_x", {28'd0, bus.mem_x}, WC ? 32'd5 : 32'd0);
    #1;
    rst = 1'b1;
    q_load = 1'b1;
    #1;
    check("mr_pos", {24'd0, bus.pos_x, bus.pos_y}, 32'd0);
    check("mr_step", {24'd0, bus.step_count}, 32'd0);
    check("mr_flags", {28'd0, bus.busy, bus.done, bus.error, bus.q_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q_load = 1'b0;
    pulse_start();
    run_until("mr_replay", 200, cyc);
    check("mr_replay_done", {31'd0, bus.done}, 32'd1);
    check("mr_replay_step", {24'd0, bus.step_count}, 32'd30);

    // Start while busy is ignored; start in DONE restarts from (0,0).
    load_path(0);
    load_path(30);
    qn = 60;
    do_reset();
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_start();
    check("ign_step", {24'd0, bus.step_count}, 32'd4);
    check("ign_pos_x", {28'd0, bus.pos_x}, 32'd4);
    run_until("ign", 200, cyc);
    check("ign_done", {31'd0, bus.done}, 32'd1);
    check("ign_final_step", {24'd0, bus.step_count}, 32'd30);
    check("ign_pops", head, 32'd30);
    pulse_start();
    check("rs_cleared", {20'd0, bus.pos_x, bus.pos_y, bus.step_count}, 32'd0);
    check("rs_flags", {29'd0, bus.busy, bus.done, bus.error}, 32'd4);
    run_until("rs", 200, cyc);
    check("rs_done", {31'd0, bus.done}, 32'd1);
    check("rs_pos", {24'd0, bus.pos_x, bus.pos_y}, 32'hFF);
    check("rs_pops", head, 32'd60);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
